// File: rtl/suma_serial_ctrl.sv
// suma_serial_ctrl: bit-serial add sequencer around one suma_1bit cell (Ovf output with SUMA_SERIAL_OVF_EN)
module suma_1bit (
   input  logic A,
   input  logic B,
   input  logic Ci,
   output logic S,
   output logic Co
);
   assign S  = A ^ B ^ Ci;
   assign Co = (A & B) | (Ci & (A ^ B));
endmodule

module suma_serial_ctrl #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Ci,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] S,
   output logic         Co
`ifdef SUMA_SERIAL_OVF_EN
   ,
   output logic         Ovf
`endif
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_d;
   logic [N-1:0] a_reg, b_reg;
   logic [CW-1:0] cnt;
   logic carry, so, co, last, accept;
   assign last   = cnt == CW'(N - 1);
   assign accept = state == IDLE && start;
   assign busy   = state == RUN;
   assign done   = state == DONE;
   suma_1bit u_add (
      .A (a_reg[cnt]),
      .B (b_reg[cnt]),
      .Ci(carry),
      .S (so),
      .Co(co)
   );
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_d;
   // next state: one RUN edge per bit, DONE lasts a single cycle
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = start ? RUN : IDLE;
         RUN:     state_d = last ? DONE : RUN;
         default: state_d = IDLE;
      endcase
   end
   // operand latch, serial bit slice and result registers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         a_reg <= '0;
         b_reg <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         S     <= '0;
         Co    <= 1'b0;
      end else if (accept) begin
         a_reg <= A;
         b_reg <= B;
         carry <= Ci;
         cnt   <= '0;
         S     <= '0;
      end else if (busy) begin
         S[cnt] <= so;
         carry  <= co;
         cnt    <= last ? '0 : cnt + CW'(1);
         if (last) Co <= co;
      end
`ifdef SUMA_SERIAL_OVF_EN
   // signed overflow: carry into the MSB differs from carry out of it
   always_ff @(posedge clk or posedge rst)
      if (rst)               Ovf <= 1'b0;
      else if (accept)       Ovf <= 1'b0;
      else if (busy && last) Ovf <= carry ^ co;
`endif
endmodule

// File: tb/tb_suma_serial_ctrl.sv
// tb_suma_serial_ctrl: randomized and directed checks of the serial adder against A+B+Ci arithmetic
module tb_suma_serial_ctrl;
   localparam int N = 4;
   logic clk = 0, rst = 1;
   logic start = 0, Ci = 0, busy, done, Co;
   logic [N-1:0] A = 0, B = 0, S;
   logic start1 = 0, a1 = 0, b1 = 0, ci1 = 0, busy1, done1, s1, co1;
   int n_chk = 0, n_fail = 0;
`ifdef SUMA_SERIAL_OVF_EN
   logic Ovf, ovf1;
`endif
   suma_serial_ctrl #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Ci(Ci),
      .busy(busy), .done(done), .S(S), .Co(Co)
`ifdef SUMA_SERIAL_OVF_EN
      , .Ovf(Ovf)
`endif
   );
   suma_serial_ctrl #(.N(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .Ci(ci1),
      .busy(busy1), .done(done1), .S(s1), .Co(co1)
`ifdef SUMA_SERIAL_OVF_EN
      , .Ovf(ovf1)
`endif
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic add4(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci, input bit hold);
      logic [N:0] e;
      e = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
      @(negedge clk);
      start = 1; A = a; B = b; Ci = ci;
      @(posedge clk); #1;
      if (!hold) start = 0;
      A = hold ? 1 : N'($urandom);
      B = hold ? 1 : N'($urandom);
      Ci = 1'($urandom);
      chk("busy_k", busy, 1);
      chk("done_k", done, 0);
      repeat (N - 1) begin
         @(posedge clk); #1;
         chk("busy_run", busy, 1);
         chk("done_run", done, 0);
      end
      @(posedge clk); #1;
      chk("done_pulse", done, 1);
      chk("busy_done", busy, 0);
      chk("sum", S, e[N-1:0]);
      chk("carry", Co, e[N]);
`ifdef SUMA_SERIAL_OVF_EN
      chk("ovf", Ovf, (a[N-1] == b[N-1]) && (e[N-1] != a[N-1]));
`endif
      @(posedge clk); #1;
      chk("done_fall", done, 0);
      chk("busy_idle", busy, 0);
      chk("sum_held", S, e[N-1:0]);
      chk("carry_held", Co, e[N]);
      start = 0;
   endtask
   task automatic add1(input logic a, input logic b, input logic ci);
      logic [1:0] e;
      e = {1'b0, a} + {1'b0, b} + {1'b0, ci};
      @(negedge clk);
      start1 = 1; a1 = a; b1 = b; ci1 = ci;
      @(posedge clk); #1;
      start1 = 0; a1 = ~a; b1 = ~b; ci1 = ~ci;
      chk("n1_busy", busy1, 1);
      @(posedge clk); #1;
      chk("n1_done", done1, 1);
      chk("n1_sum", {co1, s1}, e);
      @(posedge clk); #1;
      chk("n1_done_fall", done1, 0);
   endtask
   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", S, 0);
      chk("rst_carry", Co, 0);
`ifdef SUMA_SERIAL_OVF_EN
      chk("rst_ovf", Ovf, 0);
`endif
      @(negedge clk) rst = 0;
      add4(5, 3, 0, 0);
      add4(15, 0, 1, 0);
      add4(15, 15, 1, 0);
      @(negedge clk);
      start = 1; A = 7; B = 7; Ci = 0;
      repeat (3) @(posedge clk);
      #1;
      start = 0;
      chk("mid_busy", busy, 1);
      rst = 1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_sum", S, 0);
      chk("arst_carry", Co, 0);
      @(negedge clk) rst = 0;
      @(posedge clk); #1;
      chk("arst_idle", busy, 0);
      add4(9, 4, 0, 0);
      add4(6, 6, 0, 1);
      add4(7, 1, 0, 0);
      add4(8, 8, 0, 0);
      add4(3, 2, 0, 0);
      for (int i = 0; i < 20; i++) add4(N'($urandom), N'($urandom), 1'($urandom), 0);
      for (int i = 0; i < 8; i++) add1(i[2], i[1], i[0]);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
